// File: rtl/sfi_tag_checker.sv
// sfi_tag_checker: re-checks sandbox tags on memory-access instructions, replaces untagged ones
// with a NOP, and keeps saturating statistics plus a sticky first-violation capture.
module sfi_tag_checker #(
    parameter logic [7:0] TAG = 8'hA2,
    parameter int CNT_W = 32,
    parameter bit HALT_ON_VIOLATION = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_word,
    output logic             out_viol,
    input  logic             clr,
    output logic             alarm,
    output logic [63:0]      first_viol_word,
    output logic [CNT_W-1:0] first_viol_idx,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_viol
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic       halted;
    logic [5:0] op;
    logic       is_mem, viol, acc;
    assign op       = in_word[31:26];
    assign is_mem   = op inside {6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd56, 6'd60, 6'd63};
    assign viol     = is_mem && (in_word[63:56] != TAG);
    assign in_ready = (~out_valid | out_ready) & ~halted;
    assign acc      = in_valid & in_ready;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c != MAX) ? c + ONE : c;
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_viol  <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_word  <= viol ? 64'd0 : in_word;
            out_viol  <= viol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
    // clr wins over counting/capture but leaves the output stage to the block above
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            halted          <= 1'b0;
            alarm           <= 1'b0;
            first_viol_word <= '0;
            first_viol_idx  <= '0;
            cnt_total       <= '0;
            cnt_mem         <= '0;
            cnt_viol        <= '0;
        end else if (acc) begin
            cnt_total <= sat_inc(cnt_total);
            if (is_mem) cnt_mem <= sat_inc(cnt_mem);
            if (viol) cnt_viol <= sat_inc(cnt_viol);
            if (viol && HALT_ON_VIOLATION) halted <= 1'b1;
            if (viol && !alarm) begin
                alarm           <= 1'b1;
                first_viol_word <= in_word;
                first_viol_idx  <= cnt_total;
            end
        end
    end
endmodule
